// File: rtl/match_sequencer_pkg.sv
// recv_pkg: shared definitions for the receive-side match sequencer.
//   - response code constants returned on cpu_resp_code / net_resp_code
//   - sequencer state enum
//   - network packet field positions and opcodes
package recv_pkg;

    localparam logic [1:0] RESP_MATCH   = 2'b00;
    localparam logic [1:0] RESP_QUEUED  = 2'b01;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIND,
        ST_WAIT,
        ST_INSERT,
        ST_RESP
    } state_t;

    localparam int unsigned OPCODE_HI = 127;
    localparam int unsigned OPCODE_LO = 123;
    localparam logic [4:0]  OP_EAGER  = 5'b10000;
    localparam logic [4:0]  OP_LONG   = 5'b10001;
    localparam int unsigned MATCH_HI  = 103;
    localparam int unsigned MATCH_LO  = 88;

    function automatic logic [15:0] match_field(input logic [127:0] msg);
        return msg[MATCH_HI:MATCH_LO];
    endfunction

endpackage

// File: rtl/match_sequencer_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   nios_clk, reset : clock, synchronous active-high reset
//   req[1:0]        : request vector (bit 0 = CPU, bit 1 = network)
//   advance         : commit the current grant into last_grant
//   grant[1:0]      : one-hot grant (combinational)
// last_grant resets to CPU so the network wins the first tie.
module rr_arb2 (
    input  logic       nios_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_grant;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge nios_clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: arbitrates CPU receive requests and network arrivals for
// atomic find-then-insert transactions on the PRQ and UMQ CAMs.
//   CPU side     : cpu_req_valid/ready, cpu_request, cpu_data_ptr,
//                  cpu_resp_valid/code/data
//   network side : net_msg_valid/ready, net_msg, net_resp_valid/code/ptr
//   UMQ          : umq_find/insert strobes, umq_found/not_found/empty, umq_data
//   PRQ          : prq_find/insert strobes, prq_found/not_found/empty, prq_ptr
//   CAM operands : cam_request, cam_data_ptr, cam_message
//   status       : complete_pulse (per MATCH), timeout_err (sticky)
// All outputs are registered; the comb process computes next values.
module match_sequencer
    import recv_pkg::*;
#(
    parameter int unsigned MSG_WIDTH      = 128,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMO_W          = 11
) (
    input  logic                  nios_clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [DATA_WIDTH-1:0] cpu_request,
    input  logic [DATA_WIDTH-1:0] cpu_data_ptr,
    output logic                  cpu_resp_valid,
    output logic [1:0]            cpu_resp_code,
    output logic [DATA_WIDTH-1:0] cpu_resp_data,
    input  logic                  net_msg_valid,
    output logic                  net_msg_ready,
    input  logic [MSG_WIDTH-1:0]  net_msg,
    output logic                  net_resp_valid,
    output logic [1:0]            net_resp_code,
    output logic [DATA_WIDTH-1:0] net_resp_ptr,
    output logic                  umq_find,
    output logic                  umq_insert,
    input  logic                  umq_found,
    input  logic                  umq_not_found,
    input  logic                  umq_empty,
    input  logic [DATA_WIDTH-1:0] umq_data,
    output logic                  prq_find,
    output logic                  prq_insert,
    input  logic                  prq_found,
    input  logic                  prq_not_found,
    input  logic                  prq_empty,
    input  logic [DATA_WIDTH-1:0] prq_ptr,
    output logic [DATA_WIDTH-1:0] cam_request,
    output logic [DATA_WIDTH-1:0] cam_data_ptr,
    output logic [MSG_WIDTH-1:0]  cam_message,
    output logic                  complete_pulse,
    output logic                  timeout_err
);
    state_t state_q, state_d;
    logic   gnt_net_q, gnt_net_d;
    logic   skip_q, skip_d;
    logic [TMO_W-1:0] timer_q, timer_d;

    logic [1:0] grant;
    logic       arb_window, arb_advance;

    logic                  cpu_req_ready_d, net_msg_ready_d;
    logic                  cpu_resp_valid_d, net_resp_valid_d;
    logic [1:0]            cpu_resp_code_d, net_resp_code_d;
    logic [DATA_WIDTH-1:0] cpu_resp_data_d, net_resp_ptr_d;
    logic                  umq_find_d, umq_insert_d, prq_find_d, prq_insert_d;
    logic [DATA_WIDTH-1:0] cam_request_d, cam_data_ptr_d;
    logic [MSG_WIDTH-1:0]  cam_message_d;
    logic                  complete_pulse_d, timeout_err_d;

    logic                  resp_fire;
    logic [1:0]            resp_code;
    logic [DATA_WIDTH-1:0] resp_payload;
    logic                  target_empty, verdict_found, verdict_miss;

    // Arbitration runs in IDLE before a grant is pending, and also in RESP so
    // that a waiting requester can be accepted in the cycle right after RESP.
    assign arb_window  = ((state_q == ST_IDLE) && !cpu_req_ready && !net_msg_ready)
                         || (state_q == ST_RESP);
    assign arb_advance = arb_window;

    rr_arb2 u_arb (
        .nios_clk (nios_clk),
        .reset    (reset),
        .req      ({net_msg_valid, cpu_req_valid}),
        .advance  (arb_advance),
        .grant    (grant)
    );

    always_comb begin
        state_d          = state_q;
        gnt_net_d        = gnt_net_q;
        skip_d           = skip_q;
        timer_d          = timer_q;
        cpu_req_ready_d  = 1'b0;
        net_msg_ready_d  = 1'b0;
        cpu_resp_valid_d = 1'b0;
        net_resp_valid_d = 1'b0;
        cpu_resp_code_d  = '0;
        net_resp_code_d  = '0;
        cpu_resp_data_d  = '0;
        net_resp_ptr_d   = '0;
        umq_find_d       = 1'b0;
        umq_insert_d     = 1'b0;
        prq_find_d       = 1'b0;
        prq_insert_d     = 1'b0;
        cam_request_d    = cam_request;
        cam_data_ptr_d   = cam_data_ptr;
        cam_message_d    = cam_message;
        complete_pulse_d = 1'b0;
        timeout_err_d    = timeout_err;
        resp_fire        = 1'b0;
        resp_code        = '0;
        resp_payload     = '0;
        target_empty     = gnt_net_q ? prq_empty     : umq_empty;
        verdict_found    = gnt_net_q ? prq_found     : umq_found;
        verdict_miss     = gnt_net_q ? prq_not_found : umq_not_found;

        // Operands latch on the grant edge so cam_* is stable during the
        // accept cycle in which ready is shown.
        if (arb_window) begin
            if (grant[1]) begin
                net_msg_ready_d = 1'b1;
                cam_message_d   = net_msg;
                gnt_net_d       = 1'b1;
            end else if (grant[0]) begin
                cpu_req_ready_d = 1'b1;
                cam_request_d   = cpu_request;
                cam_data_ptr_d  = cpu_data_ptr;
                gnt_net_d       = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Accept cycle: the find strobe is registered, so the empty
                // check is made here and remembered for the FIND cycle.
                if (cpu_req_ready || net_msg_ready) begin
                    state_d = ST_FIND;
                    skip_d  = target_empty;
                    timer_d = '0;
                    if (!target_empty) begin
                        if (gnt_net_q) prq_find_d = 1'b1;
                        else           umq_find_d = 1'b1;
                    end
                end
            end
            ST_FIND: begin
                timer_d = timer_q + 1'b1;
                if (skip_q) begin
                    state_d = ST_INSERT;
                    if (gnt_net_q) umq_insert_d = 1'b1;
                    else           prq_insert_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (verdict_found) begin
                    state_d      = ST_RESP;
                    resp_fire    = 1'b1;
                    resp_code    = RESP_MATCH;
                    resp_payload = gnt_net_q ? prq_ptr : umq_data;
                end else if (verdict_miss) begin
                    state_d = ST_INSERT;
                    if (gnt_net_q) umq_insert_d = 1'b1;
                    else           prq_insert_d = 1'b1;
                end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_RESP;
                    resp_fire     = 1'b1;
                    resp_code     = RESP_TIMEOUT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_INSERT: begin
                state_d   = ST_RESP;
                resp_fire = 1'b1;
                resp_code = RESP_QUEUED;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (resp_fire) begin
            complete_pulse_d = (resp_code == RESP_MATCH);
            if (gnt_net_q) begin
                net_resp_valid_d = 1'b1;
                net_resp_code_d  = resp_code;
                net_resp_ptr_d   = resp_payload;
            end else begin
                cpu_resp_valid_d = 1'b1;
                cpu_resp_code_d  = resp_code;
                cpu_resp_data_d  = resp_payload;
            end
        end
    end

    always_ff @(posedge nios_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            gnt_net_q      <= 1'b0;
            skip_q         <= 1'b0;
            timer_q        <= '0;
            cpu_req_ready  <= 1'b0;
            net_msg_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            net_resp_valid <= 1'b0;
            cpu_resp_code  <= '0;
            net_resp_code  <= '0;
            cpu_resp_data  <= '0;
            net_resp_ptr   <= '0;
            umq_find       <= 1'b0;
            umq_insert     <= 1'b0;
            prq_find       <= 1'b0;
            prq_insert     <= 1'b0;
            cam_request    <= '0;
            cam_data_ptr   <= '0;
            cam_message    <= '0;
            complete_pulse <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_net_q      <= gnt_net_d;
            skip_q         <= skip_d;
            timer_q        <= timer_d;
            cpu_req_ready  <= cpu_req_ready_d;
            net_msg_ready  <= net_msg_ready_d;
            cpu_resp_valid <= cpu_resp_valid_d;
            net_resp_valid <= net_resp_valid_d;
            cpu_resp_code  <= cpu_resp_code_d;
            net_resp_code  <= net_resp_code_d;
            cpu_resp_data  <= cpu_resp_data_d;
            net_resp_ptr   <= net_resp_ptr_d;
            umq_find       <= umq_find_d;
            umq_insert     <= umq_insert_d;
            prq_find       <= prq_find_d;
            prq_insert     <= prq_insert_d;
            cam_request    <= cam_request_d;
            cam_data_ptr   <= cam_data_ptr_d;
            cam_message    <= cam_message_d;
            complete_pulse <= complete_pulse_d;
            timeout_err    <= timeout_err_d;
        end
    end

endmodule
